// File: rtl/ctrl_pkg.sv
// Shared encodings for the field-decoded datapath control FSM.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_FETCH_WB,
    S_DECODE,
    S_REG_EX,
    S_MEM_RD,
    S_MEM_WB,
    S_MEM_WR,
    S_ALU_1,
    S_ALU_2,
    S_JMP_RD,
    S_JMP_WB,
    S_JMP_SKIP,
    S_HALT
  } state_e;

  typedef enum logic [1:0] {
    CLS_REG = 2'b00,
    CLS_MEM = 2'b01,
    CLS_ALU = 2'b10,
    CLS_CTL = 2'b11
  } ins_class_e;

  localparam logic [1:0] SUB_RST    = 2'd0;
  localparam logic [1:0] SUB_INC    = 2'd1;
  localparam logic [1:0] SUB_MOV_AR = 2'd2;
  localparam logic [1:0] SUB_MOV_RA = 2'd3;
  localparam logic [1:0] SUB_STORE  = 2'd3;
  localparam logic [1:0] SUB_JMP    = 2'd0;
  localparam logic [1:0] SUB_JZ     = 2'd1;
  localparam logic [1:0] SUB_JNZ    = 2'd2;
  localparam logic [1:0] SUB_MISC   = 2'd3;

  localparam logic [2:0] ALU_NONE = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_MUL  = 3'd2;
  localparam logic [2:0] ALU_DIV  = 3'd3;
  localparam logic [2:0] ALU_MOD  = 3'd4;

  localparam logic [1:0] MEM_IDLE  = 2'd0;
  localparam logic [1:0] MEM_READ  = 2'd1;
  localparam logic [1:0] MEM_WRITE = 2'd2;

  localparam logic [1:0] P_GSP = 2'd0;
  localparam logic [1:0] P_RP  = 2'd1;
  localparam logic [1:0] P_CP  = 2'd2;
  localparam logic [1:0] P_STP = 2'd3;

  localparam logic [3:0] BS_MEMOUT = 4'hE;

  function automatic logic [2:0] alu_of(input logic [1:0] sub);
    case (sub)
      2'd0:    return ALU_ADD;
      2'd1:    return ALU_MUL;
      2'd2:    return ALU_DIV;
      default: return ALU_MOD;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_unit_param_if.sv
// Controller <-> datapath/memory bundle; master is the control unit side.
interface ctrl_unit_param_if #(
  parameter int NUM_REGS  = 14,
  parameter int NUM_FLAGS = 2
);
  import ctrl_pkg::*;

  logic [7:0]           ins;
  logic [NUM_FLAGS-1:0] flags;
  logic                 mem_ready;
  logic                 resume;
  logic [2:0]           alu_op;
  logic [3:0]           bus_sel;
  logic [1:0]           pctrl;
  logic [1:0]           mem_ctrl;
  logic [NUM_REGS-1:0]  wrt_en;
  logic [NUM_REGS-1:0]  inc_en;
  logic [NUM_REGS-1:0]  rst_en;
  logic                 halted;
  logic                 illegal;

  modport master (
    input  ins, flags, mem_ready, resume,
    output alu_op, bus_sel, pctrl, mem_ctrl, wrt_en, inc_en, rst_en, halted, illegal
  );

  modport slave (
    output ins, flags, mem_ready, resume,
    input  alu_op, bus_sel, pctrl, mem_ctrl, wrt_en, inc_en, rst_en, halted, illegal
  );

endinterface

// File: rtl/ctrl_decode.sv
// Combinational opcode field split and legality check for the configured register/flag counts.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int NUM_REGS  = 14,
  parameter int NUM_FLAGS = 2
) (
  input  logic [7:0] ins_i,
  output ins_class_e cls_o,
  output logic [1:0] sub_o,
  output logic [3:0] r_o,
  output logic       legal_o,
  output logic       rstall_o
);

  logic reg_ok;
  logic flag_ok;

  assign cls_o    = ins_class_e'(ins_i[7:6]);
  assign sub_o    = ins_i[5:4];
  assign r_o      = ins_i[3:0];
  assign reg_ok   = {1'b0, ins_i[3:0]} < 5'(NUM_REGS);
  assign flag_ok  = {1'b0, ins_i[3:0]} < 5'(NUM_FLAGS);
  assign rstall_o = (cls_o == CLS_REG) && (sub_o == SUB_RST) && (r_o == 4'hF);

  // JMP carries no register operand in r, so it is legal for any r.
  always_comb begin
    legal_o = 1'b0;
    case (cls_o)
      CLS_REG: legal_o = reg_ok || rstall_o;
      CLS_MEM: legal_o = reg_ok;
      CLS_ALU: legal_o = reg_ok;
      default: begin
        case (sub_o)
          SUB_JMP: legal_o = 1'b1;
          SUB_JZ:  legal_o = flag_ok;
          SUB_JNZ: legal_o = flag_ok;
          default: legal_o = (r_o <= 4'd1);
        endcase
      end
    endcase
  end

endmodule

// File: rtl/ctrl_unit_param.sv
// Datapath control FSM: fetch/decode/execute with memory wait, conditional jumps and halt.
module ctrl_unit_param
  import ctrl_pkg::*;
#(
  parameter int NUM_REGS  = 14,
  parameter int NUM_FLAGS = 2,
  parameter int PC_IDX    = 0,
  parameter int TGT_IDX   = 1,
  parameter int AC_IDX    = 13
) (
  input logic               clk,
  input logic               rst,
  ctrl_unit_param_if.master bus
);

  localparam logic [NUM_REGS-1:0] PC_MASK  = NUM_REGS'(1) << PC_IDX;
  localparam logic [NUM_REGS-1:0] TGT_MASK = NUM_REGS'(1) << TGT_IDX;
  localparam logic [NUM_REGS-1:0] AC_MASK  = NUM_REGS'(1) << AC_IDX;
  localparam logic [3:0]          AC_SEL   = 4'(AC_IDX);
  localparam logic [3:0]          TGT_SEL  = 4'(TGT_IDX);

  state_e              state_q, state_d;
  logic                illegal_q, illegal_d;
  ins_class_e          cls;
  logic [1:0]          sub;
  logic [3:0]          r;
  logic                legal;
  logic                rstall;
  logic [15:0]         flags_ext;
  logic                flag_bit;
  logic [NUM_REGS-1:0] reg_mask;

  ctrl_decode #(
    .NUM_REGS  (NUM_REGS),
    .NUM_FLAGS (NUM_FLAGS)
  ) u_decode (
    .ins_i    (bus.ins),
    .cls_o    (cls),
    .sub_o    (sub),
    .r_o      (r),
    .legal_o  (legal),
    .rstall_o (rstall)
  );

  assign flags_ext   = 16'(bus.flags);
  assign flag_bit    = flags_ext[r];
  assign reg_mask    = NUM_REGS'(1) << r;
  assign bus.illegal = illegal_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    case (state_q)
      S_FETCH:    if (bus.mem_ready) state_d = S_FETCH_WB;
      S_FETCH_WB: state_d = S_DECODE;
      S_DECODE: begin
        if (!legal) begin
          illegal_d = 1'b1;
          state_d   = S_HALT;
        end else begin
          case (cls)
            CLS_REG: state_d = S_REG_EX;
            CLS_MEM: state_d = (sub == SUB_STORE) ? S_MEM_WR : S_MEM_RD;
            CLS_ALU: state_d = S_ALU_1;
            default: begin
              case (sub)
                SUB_JMP: state_d = S_JMP_RD;
                SUB_JZ:  state_d = flag_bit ? S_JMP_RD : S_JMP_SKIP;
                SUB_JNZ: state_d = flag_bit ? S_JMP_SKIP : S_JMP_RD;
                default: state_d = r[0] ? S_HALT : S_FETCH;
              endcase
            end
          endcase
        end
      end
      S_REG_EX:   state_d = S_FETCH;
      S_MEM_RD:   if (bus.mem_ready) state_d = S_MEM_WB;
      S_MEM_WB:   state_d = S_FETCH;
      S_MEM_WR:   if (bus.mem_ready) state_d = S_FETCH;
      S_ALU_1:    state_d = S_ALU_2;
      S_ALU_2:    state_d = S_FETCH;
      S_JMP_RD:   if (bus.mem_ready) state_d = S_JMP_WB;
      S_JMP_WB:   state_d = S_FETCH;
      S_JMP_SKIP: state_d = S_FETCH;
      S_HALT:     if (bus.resume) state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  // The jump operand is latched into TGT during JMP_RD so JMP_WB can copy it to PC.
  always_comb begin
    bus.alu_op   = ALU_NONE;
    bus.bus_sel  = AC_SEL;
    bus.pctrl    = P_GSP;
    bus.mem_ctrl = MEM_IDLE;
    bus.wrt_en   = '0;
    bus.inc_en   = '0;
    bus.rst_en   = '0;
    bus.halted   = 1'b0;
    case (state_q)
      S_FETCH: bus.mem_ctrl = MEM_READ;
      S_FETCH_WB: begin
        bus.bus_sel = BS_MEMOUT;
        bus.wrt_en  = TGT_MASK;
        bus.inc_en  = PC_MASK;
      end
      S_REG_EX: begin
        case (sub)
          SUB_RST:    bus.rst_en = rstall ? '1 : reg_mask;
          SUB_INC:    bus.inc_en = reg_mask;
          SUB_MOV_AR: bus.wrt_en = reg_mask;
          default: begin
            bus.bus_sel = r;
            bus.wrt_en  = AC_MASK;
          end
        endcase
      end
      S_MEM_RD: begin
        bus.mem_ctrl = MEM_READ;
        bus.pctrl    = sub;
      end
      S_MEM_WB: begin
        bus.bus_sel = BS_MEMOUT;
        bus.wrt_en  = reg_mask;
      end
      S_MEM_WR: begin
        bus.mem_ctrl = MEM_WRITE;
        bus.pctrl    = P_STP;
      end
      S_ALU_1: begin
        bus.alu_op  = alu_of(sub);
        bus.bus_sel = r;
      end
      S_ALU_2: begin
        bus.alu_op  = alu_of(sub);
        bus.bus_sel = r;
        bus.wrt_en  = AC_MASK;
      end
      S_JMP_RD: begin
        bus.mem_ctrl = MEM_READ;
        bus.bus_sel  = BS_MEMOUT;
        bus.wrt_en   = TGT_MASK;
      end
      S_JMP_WB: begin
        bus.bus_sel = TGT_SEL;
        bus.wrt_en  = PC_MASK;
      end
      S_JMP_SKIP: bus.inc_en = PC_MASK;
      S_HALT:     bus.halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ctrl_unit_param.sv
// Directed stimulus with a per-cycle expected-output scoreboard for ctrl_unit_param.
module tb_ctrl_unit_param;

  typedef struct {
    string       nm;
    logic [2:0]  alu;
    logic [3:0]  bsel;
    logic [1:0]  pc;
    logic [1:0]  mem;
    logic [13:0] wrt;
    logic [13:0] inc;
    logic [13:0] rsts;
    logic        halt;
    logic        ill;
  } exp_t;

  logic clk;
  logic rst;
  logic exp_ill;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sbq[$];
  exp_t mon_e;

  ctrl_unit_param_if #(.NUM_REGS(14), .NUM_FLAGS(2)) bus_if ();

  ctrl_unit_param #(
    .NUM_REGS  (14),
    .NUM_FLAGS (2),
    .PC_IDX    (0),
    .TGT_IDX   (1),
    .AC_IDX    (13)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(string nm, logic [2:0] a, logic [3:0] b, logic [1:0] p,
                              logic [1:0] m, logic [13:0] w, logic [13:0] i,
                              logic [13:0] r, logic h);
    exp_t e;
    e.nm = nm; e.alu = a; e.bsel = b; e.pc = p; e.mem = m;
    e.wrt = w; e.inc = i; e.rsts = r; e.halt = h; e.ill = exp_ill;
    return e;
  endfunction

  function automatic exp_t x_fetch(string nm);
    return mk(nm, 3'd0, 4'hD, 2'd0, 2'd1, 14'h0, 14'h0, 14'h0, 1'b0);
  endfunction

  function automatic exp_t x_halt(string nm);
    return mk(nm, 3'd0, 4'hD, 2'd0, 2'd0, 14'h0, 14'h0, 14'h0, 1'b1);
  endfunction

  // One clock: drive this cycle's inputs just after the edge and queue this cycle's expected outputs.
  task automatic cyc(input logic r, input logic [7:0] i, input logic [1:0] f,
                     input logic rd, input logic rs, input exp_t e);
    @(posedge clk);
    #1;
    rst              = r;
    bus_if.ins       = i;
    bus_if.flags     = f;
    bus_if.mem_ready = rd;
    bus_if.resume    = rs;
    sbq.push_back(e);
  endtask

  task automatic pre(input logic [7:0] i, input logic [1:0] fd, input logic rs);
    cyc(1'b0, i, 2'b00, 1'b1, 1'b0, x_fetch("fetch"));
    cyc(1'b0, i, 2'b00, 1'b0, 1'b0,
        mk("fetch_wb", 3'd0, 4'hE, 2'd0, 2'd0, 14'h0002, 14'h0001, 14'h0, 1'b0));
    cyc(1'b0, i, fd, 1'b0, rs,
        mk("decode", 3'd0, 4'hD, 2'd0, 2'd0, 14'h0, 14'h0, 14'h0, 1'b0));
  endtask

  always @(negedge clk) begin
    if (sbq.size() != 0) begin
      mon_e = sbq.pop_front();
      n_checks++;
      if (bus_if.alu_op !== mon_e.alu || bus_if.bus_sel !== mon_e.bsel ||
          bus_if.pctrl !== mon_e.pc || bus_if.mem_ctrl !== mon_e.mem ||
          bus_if.wrt_en !== mon_e.wrt || bus_if.inc_en !== mon_e.inc ||
          bus_if.rst_en !== mon_e.rsts || bus_if.halted !== mon_e.halt ||
          bus_if.illegal !== mon_e.ill) begin
        n_fail++;
        $display("FAIL %s t=%0t: got alu=%0d bus=%h pctrl=%0d mem=%0d wrt=%h inc=%h rst=%h halted=%b illegal=%b; expected alu=%0d bus=%h pctrl=%0d mem=%0d wrt=%h inc=%h rst=%h halted=%b illegal=%b",
                 mon_e.nm, $time, bus_if.alu_op, bus_if.bus_sel, bus_if.pctrl, bus_if.mem_ctrl,
                 bus_if.wrt_en, bus_if.inc_en, bus_if.rst_en, bus_if.halted, bus_if.illegal,
                 mon_e.alu, mon_e.bsel, mon_e.pc, mon_e.mem, mon_e.wrt, mon_e.inc, mon_e.rsts,
                 mon_e.halt, mon_e.ill);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no end of test, required completion");
    $fatal(1);
  end

  initial begin
    rst              = 1'b1;
    exp_ill          = 1'b0;
    bus_if.ins       = 8'h00;
    bus_if.flags     = 2'b00;
    bus_if.mem_ready = 1'b0;
    bus_if.resume    = 1'b0;

    cyc(1'b1, 8'h00, 2'b00, 1'b0, 1'b0, x_fetch("reset"));
    cyc(1'b1, 8'h00, 2'b00, 1'b0, 1'b0, x_fetch("reset"));

    // register ops
    pre(8'h0F, 2'b00, 1'b0);
    cyc(1'b0, 8'h0F, 2'b00, 1'b0, 1'b0, mk("rstall", 0, 4'hD, 0, 0, 14'h0, 14'h0, 14'h3FFF, 0));
    pre(8'h05, 2'b00, 1'b0);
    cyc(1'b0, 8'h05, 2'b00, 1'b0, 1'b0, mk("rst_r5", 0, 4'hD, 0, 0, 14'h0, 14'h0, 14'h0020, 0));
    pre(8'h23, 2'b00, 1'b0);
    cyc(1'b0, 8'h23, 2'b00, 1'b0, 1'b0, mk("mov_ac_r3", 0, 4'hD, 0, 0, 14'h0008, 14'h0, 14'h0, 0));
    pre(8'h34, 2'b00, 1'b0);
    cyc(1'b0, 8'h34, 2'b00, 1'b0, 1'b0, mk("mov_r4_ac", 0, 4'h4, 0, 0, 14'h2000, 14'h0, 14'h0, 0));
    pre(8'h19, 2'b00, 1'b0);
    cyc(1'b0, 8'h19, 2'b00, 1'b0, 1'b0, mk("inc_r9", 0, 4'hD, 0, 0, 14'h0, 14'h0200, 14'h0, 0));

    // LOAD r2 via RP with three wait cycles
    pre(8'h52, 2'b00, 1'b0);
    repeat (3)
      cyc(1'b0, 8'h52, 2'b00, 1'b0, 1'b0, mk("load_wait", 0, 4'hD, 1, 1, 14'h0, 14'h0, 14'h0, 0));
    cyc(1'b0, 8'h52, 2'b00, 1'b1, 1'b0, mk("load_rd", 0, 4'hD, 1, 1, 14'h0, 14'h0, 14'h0, 0));
    cyc(1'b0, 8'h52, 2'b00, 1'b0, 1'b0, mk("load_wb", 0, 4'hE, 0, 0, 14'h0004, 14'h0, 14'h0, 0));

    // STORE with one wait
    pre(8'h70, 2'b00, 1'b0);
    cyc(1'b0, 8'h70, 2'b00, 1'b0, 1'b0, mk("store_wait", 0, 4'hD, 3, 2, 14'h0, 14'h0, 14'h0, 0));
    cyc(1'b0, 8'h70, 2'b00, 1'b1, 1'b0, mk("store_wr", 0, 4'hD, 3, 2, 14'h0, 14'h0, 14'h0, 0));

    // JZ flag1 taken, then not taken (flags only matter in DECODE)
    pre(8'hD1, 2'b10, 1'b0);
    cyc(1'b0, 8'hD1, 2'b00, 1'b1, 1'b0, mk("jz_rd", 0, 4'hE, 0, 1, 14'h0002, 14'h0, 14'h0, 0));
    cyc(1'b0, 8'hD1, 2'b00, 1'b0, 1'b0, mk("jz_wb", 0, 4'h1, 0, 0, 14'h0001, 14'h0, 14'h0, 0));
    pre(8'hD1, 2'b00, 1'b0);
    cyc(1'b0, 8'hD1, 2'b10, 1'b0, 1'b0, mk("jz_skip", 0, 4'hD, 0, 0, 14'h0, 14'h0001, 14'h0, 0));

    // JNZ flag0 taken with one operand wait
    pre(8'hE0, 2'b00, 1'b0);
    cyc(1'b0, 8'hE0, 2'b00, 1'b0, 1'b0, mk("jnz_wait", 0, 4'hE, 0, 1, 14'h0002, 14'h0, 14'h0, 0));
    cyc(1'b0, 8'hE0, 2'b00, 1'b1, 1'b0, mk("jnz_rd", 0, 4'hE, 0, 1, 14'h0002, 14'h0, 14'h0, 0));
    cyc(1'b0, 8'hE0, 2'b00, 1'b0, 1'b0, mk("jnz_wb", 0, 4'h1, 0, 0, 14'h0001, 14'h0, 14'h0, 0));

    // DIV r7 after one fetch wait
    cyc(1'b0, 8'hA7, 2'b00, 1'b0, 1'b0, x_fetch("fetch_wait"));
    pre(8'hA7, 2'b00, 1'b0);
    cyc(1'b0, 8'hA7, 2'b00, 1'b0, 1'b0, mk("alu_1", 3, 4'h7, 0, 0, 14'h0, 14'h0, 14'h0, 0));
    cyc(1'b0, 8'hA7, 2'b00, 1'b0, 1'b0, mk("alu_2", 3, 4'h7, 0, 0, 14'h2000, 14'h0, 14'h0, 0));

    // NOP goes straight back to FETCH, END halts; resume on HALT entry is ignored
    pre(8'hF0, 2'b00, 1'b0);
    pre(8'hF1, 2'b00, 1'b1);
    cyc(1'b0, 8'hF1, 2'b00, 1'b1, 1'b0, x_halt("end_halt"));
    cyc(1'b0, 8'hF1, 2'b00, 1'b1, 1'b1, x_halt("end_halt_resume"));

    // Illegal register index, sticky across resume
    pre(8'h0E, 2'b00, 1'b0);
    exp_ill = 1'b1;
    repeat (2) cyc(1'b0, 8'h0E, 2'b11, 1'b1, 1'b0, x_halt("illegal_halt"));
    cyc(1'b0, 8'h0E, 2'b00, 1'b0, 1'b1, x_halt("illegal_resume"));
    pre(8'hD2, 2'b11, 1'b0);
    cyc(1'b0, 8'hD2, 2'b00, 1'b0, 1'b1, x_halt("illegal_flag_halt"));

    // Reset in the middle of a stalled LOAD
    pre(8'h63, 2'b00, 1'b0);
    cyc(1'b0, 8'h63, 2'b00, 1'b0, 1'b0, mk("load_cp_wait", 0, 4'hD, 2, 1, 14'h0, 14'h0, 14'h0, 0));
    exp_ill = 1'b0;
    cyc(1'b1, 8'h63, 2'b00, 1'b0, 1'b0, x_fetch("reset_mid_mem_rd"));
    cyc(1'b0, 8'h63, 2'b00, 1'b0, 1'b0, x_fetch("after_reset"));

    @(negedge clk);
    #1;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard: got %0d unchecked entries, expected 0", sbq.size());
    end
    if (n_checks < 12) begin
      n_fail++;
      $display("FAIL coverage: got %0d checks, expected at least 12", n_checks);
    end
    if (bus_if.illegal !== 1'b0) begin
      n_fail++;
      $display("FAIL final_illegal: got illegal=%b, expected 0 after reset", bus_if.illegal);
    end
    if (bus_if.halted !== 1'b0) begin
      n_fail++;
      $display("FAIL final_halted: got halted=%b, expected 0", bus_if.halted);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
